// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: state, opcode, ALU and branch encodings shared by the multicycle controller.
package ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_TRAP   = 3'd6;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signals; master is the controller side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready, flag_n, flag_z, flag_c, flag_v;
  logic        instr_req, IRWrite, PCWrite, Branch, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [4:0]  ALUControl;
  modport master (
    input  instr, mem_ready, flag_n, flag_z, flag_c, flag_v,
    output instr_req, IRWrite, PCWrite, Branch, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUControl
  );
  modport slave (
    output instr, mem_ready, flag_n, flag_z, flag_c, flag_v,
    input  instr_req, IRWrite, PCWrite, Branch, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUControl
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: instruction word to ALU operation, operand select and legality.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  alu_ctrl_o,
  output logic        alu_src_o,
  output logic        illegal_o
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       f7_zero, f7_alt, unused_bits;
  assign op          = instr_i[6:0];
  assign f3          = instr_i[14:12];
  assign f7          = instr_i[31:25];
  assign f7_zero     = f7 == 7'b0000000;
  assign f7_alt      = f7 == 7'b0100000;
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    alu_src_o  = 1'b0;
    illegal_o  = 1'b1;
    case (op)
      OP_R: begin
        alu_ctrl_o = alu_op(f3, f7_alt);
        illegal_o  = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_I: begin
        alu_ctrl_o = alu_op(f3, f3 == 3'b101 && f7_alt);
        alu_src_o  = 1'b1;
        illegal_o  = (f3 == 3'b001 && !f7_zero) || (f3 == 3'b101 && !(f7_zero || f7_alt));
      end
      OP_LOAD, OP_STORE: begin
        alu_src_o = 1'b1;
        illegal_o = f3 != 3'b010;
      end
      OP_BRANCH: begin
        alu_ctrl_o = ALU_SUB;
        illegal_o  = f3 == 3'b010 || f3 == 3'b011;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath with
// ready-handshaked memory, branch resolution and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic [4:0]       dec_alu;
  logic             dec_src, dec_ill;
  logic [6:0]       op;
  logic [2:0]       f3;
  logic             is_ld, is_st, is_br, lt, taken, alu_live;
  alu_decoder u_dec (
    .instr_i   (bus.instr),
    .alu_ctrl_o(dec_alu),
    .alu_src_o (dec_src),
    .illegal_o (dec_ill)
  );
  assign op       = bus.instr[6:0];
  assign f3       = bus.instr[14:12];
  assign is_ld    = op == OP_LOAD;
  assign is_st    = op == OP_STORE;
  assign is_br    = op == OP_BRANCH;
  assign lt       = bus.flag_n ^ bus.flag_v;
  // C set means no borrow, so unsigned less-than is !C
  assign taken    = f3 == F3_BEQ  ? bus.flag_z  :
                    f3 == F3_BNE  ? !bus.flag_z :
                    f3 == F3_BLT  ? lt          :
                    f3 == F3_BGE  ? !lt         :
                    f3 == F3_BLTU ? !bus.flag_c : bus.flag_c;
  assign alu_live = state_q inside {S_EXEC, S_MEM, S_WB};
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec_ill ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = is_br ? S_FETCH : (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:    state_d = !bus.mem_ready ? S_MEM : is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end
  assign bus.instr_req  = state_q == S_FETCH;
  assign bus.IRWrite    = state_q == S_FETCH && bus.mem_ready;
  assign bus.MemRead    = state_q == S_MEM && is_ld;
  assign bus.MemWrite   = state_q == S_MEM && is_st;
  assign bus.RegWrite   = state_q == S_WB;
  assign bus.MemtoReg   = state_q == S_WB && is_ld;
  assign bus.PCWrite    = (state_q == S_EXEC && is_br) || (state_q == S_MEM && is_st && bus.mem_ready)
                        || state_q == S_WB;
  assign bus.Branch     = state_q == S_EXEC && is_br && taken;
  assign bus.ALUControl = alu_live ? dec_alu : ALU_ADD;
  assign bus.ALUSrc     = alu_live && dec_src;
  assign illegal        = state_q == S_TRAP;
  assign retired        = retired_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.PCWrite) retired_q <= retired_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream with wait states, scored against a
// spec-level model; plus directed trap, mid-access reset and counter-wrap checks.
module tb_multicycle_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic        fn = 1'b0, fz = 1'b0, fc = 1'b0, fv = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        illegal, illegal4;
  logic [31:0] retired;
  logic [3:0]  retired4;
  multicycle_ctrl_if b ();
  multicycle_ctrl_if b4 ();
  assign b.instr = instr;
  assign b.mem_ready = mem_ready;
  assign b.flag_n = fn;
  assign b.flag_z = fz;
  assign b.flag_c = fc;
  assign b.flag_v = fv;
  assign b4.instr = instr;
  assign b4.mem_ready = mem_ready;
  assign b4.flag_n = fn;
  assign b4.flag_z = fz;
  assign b4.flag_c = fc;
  assign b4.flag_v = fv;
  multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b), .illegal(illegal), .retired(retired));
  multicycle_ctrl #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4), .illegal(illegal4), .retired(retired4));
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  typedef struct {
    logic [4:0]  alu;
    logic        src, br, mtr;
    int          lat, nrd, nwr, nrw;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];
  int   n_ret = 0;

  function automatic logic [4:0] m_alu(input logic [31:0] i);
    logic [4:0] base [8];
    logic [2:0] f3;
    base = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    f3 = i[14:12];
    if (i[6:0] == BR) return 5'd1;
    if (i[6:0] == R) return base[f3] + {4'b0, i[30] && (f3 == 3'd0 || f3 == 3'd5)};
    if (i[6:0] == I) return base[f3] + {4'b0, i[30] && f3 == 3'd5};
    return 5'd0;
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic n, z, c, v);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      default: return c;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k = $urandom_range(0, 4);
    logic [31:0] r = $urandom;
    logic [2:0]  f3 = 3'($urandom);
    logic [6:0]  f7 = r[31:25];
    logic [6:0]  op = R;
    case (k)
      0: begin op = R; f7 = ((f3 == 0 || f3 == 5) && r[0]) ? 7'h20 : 7'h00; end
      1: begin op = I; if (f3 == 1) f7 = 7'h00; else if (f3 == 5) f7 = r[0] ? 7'h20 : 7'h00; end
      2: begin op = LD; f3 = 3'd2; end
      3: begin op = ST; f3 = 3'd2; end
      default: begin op = BR; if (f3 == 2 || f3 == 3) f3 = f3 + 3'd4; end
    endcase
    return {f7, r[24:15], f3, r[11:7], op};
  endfunction

  function automatic logic [13:0] strobes();
    return {b.instr_req, b.IRWrite, b.PCWrite, b.Branch, b.ALUSrc, b.MemtoReg, b.RegWrite,
            b.MemRead, b.MemWrite, b.ALUControl};
  endfunction

  // answer the pending fetch (fetch=1) or data access after w wait cycles
  task automatic access(input bit fetch, input int w, input logic [31:0] nxt, input logic [3:0] flg);
    int t = 0;
    @(negedge clk);
    while (!(fetch ? b.instr_req : (b.MemRead || b.MemWrite)) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(fetch ? "fetch_req_timeout" : "mem_req_timeout", t < 100, 1);
    repeat (w) @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    if (fetch) begin
      instr = nxt;
      {fn, fz, fc, fv} = flg;
    end
  endtask

  task automatic issue(input logic [31:0] nxt, input int wf, input int wm, input logic [3:0] flg);
    exp_t e;
    logic [6:0] op;
    op = nxt[6:0];
    access(1'b1, wf, nxt, flg);
    e.alu = m_alu(nxt);
    e.src = op == I || op == LD || op == ST;
    e.br  = op == BR && m_taken(nxt[14:12], flg[3], flg[2], flg[1], flg[0]);
    e.mtr = op == LD;
    e.lat = op == BR ? 3 : op == LD ? 5 + wm : op == ST ? 4 + wm : 4;
    e.nrd = op == LD ? wm + 1 : 0;
    e.nwr = op == ST ? wm + 1 : 0;
    e.nrw = (op == R || op == I || op == LD) ? 1 : 0;
    e.ret = n_ret;
    n_ret++;
    q.push_back(e);
    if (op == LD || op == ST) access(1'b0, wm, 32'h0, 4'h0);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_timeout", t < 100, 1);
  endtask

  bit   mon_en = 0, busy = 0, fetch_ph = 0, gap = 0, leak = 0;
  int   cyc, nrd, nwr, nrw, nir;
  exp_t m;
  always @(negedge clk) if (mon_en) begin
    if (!busy && b.instr_req) begin
      busy = 1; fetch_ph = 1; gap = 0; leak = 0;
      cyc = 0; nrd = 0; nwr = 0; nrw = 0; nir = 0;
    end
    if (busy) begin
      if (fetch_ph) begin
        if (!b.instr_req) gap = 1;
        if (b.ALUControl != 5'd0 || b.ALUSrc) leak = 1;
        if (b.IRWrite) fetch_ph = 0;
      end
      if (!fetch_ph) cyc++;
      nrd += int'(b.MemRead);
      nwr += int'(b.MemWrite);
      nrw += int'(b.RegWrite);
      nir += int'(b.IRWrite);
      if (b.PCWrite) begin
        busy = 0;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: PCWrite with no instruction outstanding");
        end else begin
          m = q.pop_front();
          chk("alu_ctrl", b.ALUControl, m.alu);
          chk("alu_src", b.ALUSrc, m.src);
          chk("branch_sel", b.Branch, m.br);
          chk("memtoreg", b.MemtoReg, m.mtr);
          chk("retired", retired, m.ret);
          chk("retired_w4", retired4, m.ret[3:0]);
          chk("latency", cyc, m.lat);
          chk("memread_cycles", nrd, m.nrd);
          chk("memwrite_cycles", nwr, m.nwr);
          chk("regwrite_cycles", nrw, m.nrw);
          chk("irwrite_cycles", nir, 1);
          chk("fetch_req_gap", gap, 0);
          chk("alu_leak_fetch", leak, 0);
          chk("illegal_clear", illegal, 0);
        end
      end
    end
  end

  task automatic trap_test(input logic [31:0] bad_i);
    bit hit = 0;
    access(1'b1, 0, bad_i, 4'h0);
    chk("decode_illegal_low", illegal, 0);
    @(posedge clk);
    #1;
    chk("trap_illegal", illegal, 1);
    chk("trap_quiet", strobes(), 0);
    repeat (20) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      hit |= b.instr_req || b.PCWrite || b.RegWrite;
    end
    mem_ready = 1'b0;
    chk("trap_no_fetch", hit, 0);
    chk("trap_sticky", illegal, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_clears_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("trap_refetch", b.instr_req, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("reset_strobes", strobes(), 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_retired", retired, 0);
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1 chk("fetch_after_idle", b.instr_req, 1);
    issue(32'h002081B3, 0, 0, 4'h0);
    issue(32'h402081B3, 0, 0, 4'h0);
    issue(32'h4030D193, 1, 0, 4'h0);
    issue(32'h0020B1B3, 0, 0, 4'h0);
    issue(32'h0080A283, 0, 3, 4'h0);
    issue(32'h0050A423, 0, 2, 4'h0);
    issue(32'h0020C463, 0, 0, 4'b1000);
    issue(32'h0020C463, 0, 0, 4'b1001);
    issue(32'h0020F463, 0, 0, 4'b0010);
    issue(32'h0020F463, 2, 0, 4'b0000);
    repeat (7) issue(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom));
    drain();
    chk("count_17", retired, 17);
    chk("wrap_17", retired4, 1);
    repeat (31) issue(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom));
    drain();
    chk("count_48", retired, 48);
    chk("wrap_48", retired4, 0);
    mon_en = 0;
    trap_test(32'h0000007F);
    trap_test(32'h022081B3);
    access(1'b1, 0, 32'h002081B3, 4'h0);
    access(1'b1, 0, 32'h0050A423, 4'h0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!b.MemWrite && t < 20);
    @(negedge clk);
    chk("sw_write_held", b.MemWrite, 1);
    chk("sw_no_regwrite", b.RegWrite, 0);
    chk("pre_reset_retired", retired, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_memwrite", b.MemWrite, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("refetch_after_rst", b.instr_req, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
